// File: rtl/dallanma_cozum_kuyrugu_pkg.sv
// Shared types and constants for the branch resolution queue.
// Entry layout is fixed by IDX_W below; the top's IDX_W parameter defaults to it.
package dallanma_cozum_kuyrugu_pkg;

  localparam int IDX_W_VARSAYILAN = 5;
  localparam logic [31:0] PC_ADIM = 32'd4;

  typedef struct packed {
    logic                        yon;
    logic [IDX_W_VARSAYILAN-1:0] adres;
    logic [31:0]                 pc;
  } dallanma_giris_t;

  // Fall-through address of a branch that was wrongly predicted taken.
  function automatic logic [31:0] sonraki_pc(input logic [31:0] pc);
    return pc + PC_ADIM;
  endfunction

endpackage

// File: rtl/dallanma_fifo_bellek.sv
// Entry storage for the resolution queue: synchronous write at tail,
// combinational read at head. Storage is intentionally not reset.
module dallanma_fifo_bellek
  import dallanma_cozum_kuyrugu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                 i_saat,
  input  logic                 i_yaz,
  input  logic [PTR_W-1:0]     i_yaz_adr,
  input  dallanma_giris_t      i_yaz_veri,
  input  logic [PTR_W-1:0]     i_oku_adr,
  output dallanma_giris_t      o_oku_veri
);

  dallanma_giris_t bellek [DEPTH];

  always_ff @(posedge i_saat) begin
    if (i_yaz) begin
      bellek[i_yaz_adr] <= i_yaz_veri;
    end
  end

  assign o_oku_veri = bellek[i_oku_adr];

endmodule

// File: rtl/dallanma_cozum_kuyrugu.sv
// In-order branch resolution queue: compares each resolved outcome against
// its stored prediction and emits registered predictor updates and redirects.
module dallanma_cozum_kuyrugu
  import dallanma_cozum_kuyrugu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = IDX_W_VARSAYILAN
) (
  input  logic             i_saat,
  input  logic             i_reset,
  input  logic             i_tahmin_gecerli,
  input  logic             i_tahmin_yon,
  input  logic [IDX_W-1:0] i_tahmin_adres,
  input  logic [31:0]      i_tahmin_pc,
  input  logic             i_coz_gecerli,
  input  logic             i_coz_atladi,
  input  logic [31:0]      i_coz_hedef,
  output logic             o_dolu,
  output logic             o_bos,
  output logic             o_guncelle_gecerli,
  output logic [IDX_W-1:0] o_guncelle_adres,
  output logic             o_guncelle_atladi,
  output logic             o_ongoru_yanlis,
  output logic [31:0]      o_duzeltme_pc,
  output logic             o_hata
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int SAYAC_W = PTR_W + 1;

  // Handshake: a push is taken when i_tahmin_gecerli is high and o_dolu was low
  // after the previous edge; a resolve is taken when i_coz_gecerli is high and
  // o_bos was low. There is no back-pressure toward the predictor.

  logic [PTR_W-1:0]   bas;
  logic [PTR_W-1:0]   kuyruk;
  logic [SAYAC_W-1:0] sayac;

  dallanma_giris_t    bas_giris;
  dallanma_giris_t    yaz_giris;

  logic itme_kabul;
  logic coz_kabul;
  logic yanlis;
  logic yaz_en;

  assign o_dolu = (sayac == SAYAC_W'(DEPTH));
  assign o_bos  = (sayac == '0);

  assign itme_kabul = i_tahmin_gecerli && !o_dolu;
  assign coz_kabul  = i_coz_gecerli && !o_bos;
  assign yanlis     = coz_kabul && (bas_giris.yon != i_coz_atladi);
  // A push alongside a mispredict lies on the wrong path and is dropped.
  assign yaz_en     = itme_kabul && !yanlis;

  always_comb begin
    yaz_giris       = '0;
    yaz_giris.yon   = i_tahmin_yon;
    yaz_giris.adres = i_tahmin_adres;
    yaz_giris.pc    = i_tahmin_pc;
  end

  dallanma_fifo_bellek #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_bellek (
    .i_saat     (i_saat),
    .i_yaz      (yaz_en),
    .i_yaz_adr  (kuyruk),
    .i_yaz_veri (yaz_giris),
    .i_oku_adr  (bas),
    .o_oku_veri (bas_giris)
  );

  always_ff @(posedge i_saat) begin
    if (i_reset) begin
      bas                <= '0;
      kuyruk             <= '0;
      sayac              <= '0;
      o_guncelle_gecerli <= 1'b0;
      o_guncelle_adres   <= '0;
      o_guncelle_atladi  <= 1'b0;
      o_ongoru_yanlis    <= 1'b0;
      o_duzeltme_pc      <= '0;
      o_hata             <= 1'b0;
    end else begin
      o_guncelle_gecerli <= coz_kabul;
      o_guncelle_adres   <= coz_kabul ? bas_giris.adres : '0;
      o_guncelle_atladi  <= coz_kabul && i_coz_atladi;
      o_ongoru_yanlis    <= yanlis;
      o_duzeltme_pc      <= '0;

      if (yanlis) begin
        o_duzeltme_pc <= i_coz_atladi ? i_coz_hedef : sonraki_pc(bas_giris.pc);
        bas           <= '0;
        kuyruk        <= '0;
        sayac         <= '0;
      end else begin
        if (coz_kabul) begin
          bas <= bas + PTR_W'(1);
        end
        if (itme_kabul) begin
          kuyruk <= kuyruk + PTR_W'(1);
        end
        sayac <= sayac + SAYAC_W'(itme_kabul) - SAYAC_W'(coz_kabul);
      end

      if ((i_tahmin_gecerli && o_dolu) || (i_coz_gecerli && o_bos)) begin
        o_hata <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dallanma_cozum_kuyrugu.sv
// Bench for the branch resolution queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_dallanma_cozum_kuyrugu;

  localparam int DEPTH = 4;
  localparam int IDX_W = 5;

  logic             i_saat;
  logic             i_reset;
  logic             i_tahmin_gecerli;
  logic             i_tahmin_yon;
  logic [IDX_W-1:0] i_tahmin_adres;
  logic [31:0]      i_tahmin_pc;
  logic             i_coz_gecerli;
  logic             i_coz_atladi;
  logic [31:0]      i_coz_hedef;
  logic             o_dolu;
  logic             o_bos;
  logic             o_guncelle_gecerli;
  logic [IDX_W-1:0] o_guncelle_adres;
  logic             o_guncelle_atladi;
  logic             o_ongoru_yanlis;
  logic [31:0]      o_duzeltme_pc;
  logic             o_hata;

  dallanma_cozum_kuyrugu #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .i_saat             (i_saat),
    .i_reset            (i_reset),
    .i_tahmin_gecerli   (i_tahmin_gecerli),
    .i_tahmin_yon       (i_tahmin_yon),
    .i_tahmin_adres     (i_tahmin_adres),
    .i_tahmin_pc        (i_tahmin_pc),
    .i_coz_gecerli      (i_coz_gecerli),
    .i_coz_atladi       (i_coz_atladi),
    .i_coz_hedef        (i_coz_hedef),
    .o_dolu             (o_dolu),
    .o_bos              (o_bos),
    .o_guncelle_gecerli (o_guncelle_gecerli),
    .o_guncelle_adres   (o_guncelle_adres),
    .o_guncelle_atladi  (o_guncelle_atladi),
    .o_ongoru_yanlis    (o_ongoru_yanlis),
    .o_duzeltme_pc      (o_duzeltme_pc),
    .o_hata             (o_hata)
  );

  // clock / reset
  initial i_saat = 1'b0;
  always #5 i_saat = ~i_saat;

  // reference model state
  typedef struct {
    logic             yon;
    logic [IDX_W-1:0] adres;
    logic [31:0]      pc;
  } m_giris_t;

  m_giris_t m_q[$];
  logic     m_hata;

  logic             e_gunc;
  logic [IDX_W-1:0] e_adres;
  logic             e_atladi;
  logic             e_yanlis;
  logic [31:0]      e_pc;

  int toplam = 0;
  int gecen  = 0;

  task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                         input logic [31:0] beklenen);
    toplam++;
    if (gozlenen === beklenen) begin
      gecen++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", etiket, gozlenen, beklenen, $time);
    end
  endtask

  task automatic cikislari_kontrol();
    kontrol("dolu",   32'(o_dolu),             32'(m_q.size() == DEPTH));
    kontrol("bos",    32'(o_bos),              32'(m_q.size() == 0));
    kontrol("hata",   32'(o_hata),             32'(m_hata));
    kontrol("gunc",   32'(o_guncelle_gecerli), 32'(e_gunc));
    kontrol("adres",  32'(o_guncelle_adres),   32'(e_adres));
    kontrol("atladi", 32'(o_guncelle_atladi),  32'(e_atladi));
    kontrol("yanlis", 32'(o_ongoru_yanlis),    32'(e_yanlis));
    kontrol("dpc",    o_duzeltme_pc,           e_pc);
  endtask

  // driver: one clock cycle of stimulus plus model step and output check
  task automatic adim(input logic p, input logic py, input logic [IDX_W-1:0] pa,
                      input logic [31:0] ppc, input logic c, input logic ca,
                      input logic [31:0] ch);
    logic dolu_once;
    m_giris_t h;
    @(negedge i_saat);
    i_tahmin_gecerli = p;
    i_tahmin_yon     = py;
    i_tahmin_adres   = pa;
    i_tahmin_pc      = ppc;
    i_coz_gecerli    = c;
    i_coz_atladi     = ca;
    i_coz_hedef      = ch;

    dolu_once = (m_q.size() == DEPTH);
    e_gunc = 0; e_adres = '0; e_atladi = 0; e_yanlis = 0; e_pc = '0;
    if (p && dolu_once) m_hata = 1'b1;
    if (c && m_q.size() == 0) m_hata = 1'b1;
    if (c && m_q.size() != 0) begin
      h = m_q.pop_front();
      e_gunc   = 1'b1;
      e_adres  = h.adres;
      e_atladi = ca;
      if (h.yon != ca) begin
        e_yanlis = 1'b1;
        e_pc     = ca ? ch : h.pc + 32'd4;
        m_q.delete();
      end
    end
    if (p && !dolu_once && !e_yanlis) begin
      h.yon = py; h.adres = pa; h.pc = ppc;
      m_q.push_back(h);
    end

    @(posedge i_saat);
    #1;
    cikislari_kontrol();
  endtask

  task automatic bos_adim();
    adim(0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic it(input logic py, input logic [IDX_W-1:0] pa, input logic [31:0] ppc);
    adim(1, py, pa, ppc, 0, 0, '0);
  endtask

  task automatic coz(input logic ca, input logic [31:0] ch);
    adim(0, 0, '0, '0, 1, ca, ch);
  endtask

  // reset, optionally with a resolve offered during it
  task automatic sifirla(input logic coz_ile);
    @(negedge i_saat);
    i_reset          = 1'b1;
    i_tahmin_gecerli = coz_ile;
    i_coz_gecerli    = coz_ile;
    i_coz_atladi     = 1'b0;
    @(negedge i_saat);
    i_reset          = 1'b0;
    i_tahmin_gecerli = 1'b0;
    i_coz_gecerli    = 1'b0;
    m_q.delete();
    m_hata = 1'b0;
    e_gunc = 0; e_adres = '0; e_atladi = 0; e_yanlis = 0; e_pc = '0;
    cikislari_kontrol();
  endtask

  initial begin
    i_reset = 1'b1;
    i_tahmin_gecerli = 0; i_tahmin_yon = 0; i_tahmin_adres = '0; i_tahmin_pc = '0;
    i_coz_gecerli = 0; i_coz_atladi = 0; i_coz_hedef = '0;
    m_hata = 1'b0;
    repeat (2) @(posedge i_saat);
    sifirla(1'b0);

    // correct taken prediction
    it(1, 5'h0A, 32'h100);
    coz(1, 32'h0);
    kontrol("t1_gunc", 32'(o_guncelle_gecerli), 32'd1);
    kontrol("t1_adr",  32'(o_guncelle_adres),   32'h0A);
    bos_adim();

    // predicted taken, actually not taken -> fall-through
    it(1, 5'h03, 32'h200);
    coz(0, 32'hDEAD0000);
    kontrol("t2_pc", o_duzeltme_pc, 32'h204);

    // predicted not taken, actually taken -> target
    it(0, 5'h07, 32'h300);
    coz(1, 32'h340);
    kontrol("t3_pc", o_duzeltme_pc, 32'h340);

    // fill, overflow, drain in order
    for (int i = 0; i < DEPTH; i++) it(i[0], IDX_W'(i + 1), 32'h1000 + 32'(i * 4));
    it(1, 5'h1F, 32'h2000);
    kontrol("t4_hata", 32'(o_hata), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      coz(m_q[0].yon, 32'h0);
      kontrol("t4_sira", 32'(o_guncelle_adres), 32'(i + 1));
    end

    // mispredict flush with a same-cycle push, then resolve on empty
    sifirla(1'b0);
    for (int i = 0; i < 3; i++) it(1, IDX_W'(i + 8), 32'h400 + 32'(i * 4));
    adim(1, 1, 5'h1E, 32'h500, 1, 0, 32'h0);
    coz(1, 32'h0);

    // reset mid-stream discards entries, no strobe
    sifirla(1'b0);
    it(1, 5'h01, 32'h600);
    it(0, 5'h02, 32'h604);
    sifirla(1'b1);
    kontrol("t6_gunc", 32'(o_guncelle_gecerli), 32'd0);

    // steady push + correct resolve, pointers wrap
    it(1, 5'h10, 32'h700);
    for (int i = 0; i < 10; i++)
      adim(1, i[1], IDX_W'(i + 17), 32'h800 + 32'(i * 4), 1, m_q[0].yon, 32'h0);

    // random traffic
    sifirla(1'b0);
    for (int i = 0; i < 600; i++) begin
      logic p, c, ca;
      p  = ($urandom_range(0, 99) < 60);
      c  = (m_q.size() != 0) ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 3);
      ca = (m_q.size() != 0 && $urandom_range(0, 99) < 85) ? m_q[0].yon : 1'($urandom);
      adim(p, 1'($urandom), IDX_W'($urandom), $urandom, c, ca, $urandom);
      if (m_hata && $urandom_range(0, 99) < 10) sifirla(1'b0);
    end

    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule

// File: doc/dallanma_cozum_kuyrugu.md
# dallanma_cozum_kuyrugu

In-order branch resolution queue: the update/feedback end of the gshare predictor interface. Fetch pushes each predicted branch with its predictor table index, direction and PC. Execute resolves branches in program order. The block compares outcome against prediction and drives the following outputs, all registered:
- predictor counter/history update;
- mispredict pulse;
- redirect PC.

## Interface
Parameters:
- DEPTH, 4, in-flight branch entries; power of two, ≥2
- IDX_W, 5, predictor table index width

Ports:
- i_saat  in  1  clock, rising edge
- i_reset  in  1  reset i_reset, synchronous, active-high
- i_tahmin_gecerli  in  1  push a predicted branch this cycle
- i_tahmin_yon  in  1  predicted direction, 1 = taken
- i_tahmin_adres  in  IDX_W  predictor table index used for the prediction
- i_tahmin_pc  in  32  branch PC
- i_coz_gecerli  in  1  execute resolves the oldest in-flight branch
- i_coz_atladi  in  1  actual outcome, 1 = taken
- i_coz_hedef  in  32  actual taken target
- o_dolu  out  1  queue full; fetch must stall pushes
- o_bos  out  1  queue empty
- o_guncelle_gecerli  out  1  one-cycle update strobe to predictor
- o_guncelle_adres  out  IDX_W  table index to update
- o_guncelle_atladi  out  1  outcome for counter/history shift
- o_ongoru_yanlis  out  1  one-cycle mispredict pulse
- o_duzeltme_pc  out  32  redirect PC, valid with o_ongoru_yanlis
- o_hata  out  1  sticky protocol error: push when full or resolve when empty

## Operation
- Circular buffer of DEPTH entries {yon, adres[IDX_W], pc[32]}.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Occupancy counter is log2(DEPTH)+1 bits, range 0..DEPTH.
- o_dolu = (count==DEPTH); o_bos = (count==0); both combinational from the count register.

Push:
- Accepted when i_tahmin_gecerli && !full.
- Writes at the tail, tail+1.

Resolve:
- Accepted when i_coz_gecerli && !empty.
- Reads the head entry H.
- Update outputs: o_guncelle_gecerli=1, o_guncelle_adres=H.adres, o_guncelle_atladi=i_coz_atladi.
- Mispredict when H.yon != i_coz_atladi:
  - o_ongoru_yanlis=1.
  - o_duzeltme_pc = i_coz_atladi ? i_coz_hedef : H.pc+32'd4, modulo 2^32.
  - Whole queue flushes: head=tail=0, count=0. All younger entries are wrong-path.
  - A push in the same cycle is discarded.
- Correct prediction: head+1, count-1.

Simultaneous events:
- Push and correct resolve in the same cycle: count unchanged; both pointers advance.
- Push while full, even with a same-cycle resolve: rejected. Fetch must respect o_dolu from the previous edge.

Protocol errors:
- Push while full: entry dropped, o_hata set.
- Resolve while empty: ignored, no update strobe, o_hata set.
- o_hata clears only on reset.

Reset:
- All outputs 0, pointers 0, count 0; entry storage need not be cleared.
- Reset mid-operation discards all in-flight entries, with no update strobe emitted.

## Timing
- Update and mispredict outputs are registered: asserted on the edge after the resolving cycle and held exactly one cycle.
- When no resolve is accepted, all update/mispredict outputs and o_duzeltme_pc return to 0.
- o_dolu/o_bos reflect state after the most recent edge.
- Throughput: one push plus one resolve per cycle.
- Push-to-resolve minimum: a branch pushed at edge N is resolvable in the cycle after N.
- The predictor consumes o_guncelle_* the cycle it sees them; no handshake back.

## Structure
- Shared package:
  - IDX_W default.
  - Entry struct typedef {yon, adres, pc}.
  - Constant PC_ADIM = 32'd4.
- One natural sub-module, `dallanma_fifo_bellek`:
  - DEPTH×entry register array.
  - Synchronous write port, asynchronous read port at head.
- Pointer, count, flush and compare logic live in the top.

## Test plan
- Reset, then push {yon=1, adres=5'h0A, pc=32'h100}; resolve taken → next cycle o_guncelle_gecerli=1, adres=0A, atladi=1, o_ongoru_yanlis=0; o_bos=1.
- Push {yon=1, pc=32'h200}; resolve not-taken → o_ongoru_yanlis=1, o_duzeltme_pc=32'h204.
- Push {yon=0}; resolve taken with i_coz_hedef=32'h340 → o_duzeltme_pc=32'h340.
- Push 4 entries (DEPTH=4) → o_dolu=1; 5th push dropped, o_hata=1. Resolve all four correctly → strobes in FIFO order of adres, o_bos=1.
- Push 3 entries; first resolves mispredicted while a push is offered the same cycle → count=0, push discarded, next resolve sets o_hata.
- Push 2 entries and assert i_reset mid-stream → no update strobes, o_bos=1, o_hata=0. Run 10 cycles of simultaneous push+correct resolve → count stays constant and pointers wrap without loss.
